// File: rtl/jump_pc.sv
// rtl/jump_pc.sv - program counter with flag register and conditional jump; optional self-loop halt detect (HALT_DETECT_EN)
module jump_pc #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             FLAG_WE,
  input  logic [2:0]       JMP,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] PC,
  output logic             ZR,
  output logic             NG,
  output logic             TAKEN,
  output logic             HALT
);

  localparam int NBYTES = WIDTH / 8;

  logic [NBYTES-1:0] byte_or;
  logic              zero_det;
  logic              neg_det;
  logic              cond;
  logic              halted;

  // per-byte OR slices feeding a single final OR for the zero detect
  genvar g;
  generate
    for (g = 0; g < NBYTES; g++) begin : g_byte_or
      assign byte_or[g] = |ALU_OUT[g*8 +: 8];
    end
  endgenerate

  assign zero_det = ~(|byte_or);
  assign neg_det  = ALU_OUT[WIDTH-1];

  // jump decision uses the registered flags, so a same-edge flag write sees old values
  assign cond = (JMP[2] & NG) | (JMP[1] & ZR) | (JMP[0] & ~ZR & ~NG);

`ifdef HALT_DETECT_EN
  logic halt_q;

  // sticky halt once a self-jump (unconditional jump to the current PC) executes
  always_ff @(posedge CLK) begin
    if (RST) begin
      halt_q <= 1'b0;
    end else if (!halt_q && EN && (JMP == 3'b111) && (A == PC)) begin
      halt_q <= 1'b1;
    end
  end

  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  assign HALT = halted;

  // PC, flags and taken indicator; reset wins over everything, halt freezes state
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC    <= RESET_VEC;
      ZR    <= 1'b0;
      NG    <= 1'b0;
      TAKEN <= 1'b0;
    end else if (halted) begin
      TAKEN <= 1'b0;
    end else begin
      if (FLAG_WE) begin
        ZR <= zero_det;
        NG <= neg_det;
      end
      if (EN && cond) begin
        PC    <= A;
        TAKEN <= 1'b1;
      end else if (EN) begin
        PC    <= PC + WIDTH'(1);
        TAKEN <= 1'b0;
      end else begin
        TAKEN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jump_pc.sv
// tb/tb_jump_pc.sv - directed self-checking bench for jump_pc
module tb_jump_pc;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [15:0] ALU_OUT;
  logic        FLAG_WE;
  logic [2:0]  JMP;
  logic [15:0] A;
  logic [15:0] PC;
  logic        ZR;
  logic        NG;
  logic        TAKEN;
  logic        HALT;

  int total = 0;
  int bad   = 0;

  jump_pc #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .ALU_OUT(ALU_OUT), .FLAG_WE(FLAG_WE),
    .JMP(JMP), .A(A), .PC(PC), .ZR(ZR), .NG(NG), .TAKEN(TAKEN), .HALT(HALT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_pc(input string tag, input logic [15:0] epc, input logic etk);
    check({tag, "_pc"}, {16'h0, PC}, {16'h0, epc});
    check({tag, "_taken"}, {31'h0, TAKEN}, {31'h0, etk});
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; FLAG_WE = 1'b0; ALU_OUT = 16'h0; JMP = 3'b000; A = 16'h0;
    step(); step();
    chk_pc("reset", 16'h0000, 1'b0);
    check("reset_zr", {31'h0, ZR}, 32'h0);
    check("reset_ng", {31'h0, NG}, 32'h0);
    check("reset_halt", {31'h0, HALT}, 32'h0);

    // sequential advance from the reset vector
    RST = 1'b0; EN = 1'b1; JMP = 3'b000;
    step(); chk_pc("seq1", 16'h0001, 1'b0);
    step(); chk_pc("seq2", 16'h0002, 1'b0);
    step(); chk_pc("seq3", 16'h0003, 1'b0);

    // zero flag then JEQ jump
    EN = 1'b0; FLAG_WE = 1'b1; ALU_OUT = 16'h0000;
    step();
    check("zero_zr", {31'h0, ZR}, 32'h1);
    check("zero_ng", {31'h0, NG}, 32'h0);
    chk_pc("zero_hold", 16'h0003, 1'b0);
    FLAG_WE = 1'b0; EN = 1'b1; JMP = 3'b010; A = 16'h0040;
    step(); chk_pc("jeq", 16'h0040, 1'b1);
    JMP = 3'b000;
    step(); chk_pc("jeq_after", 16'h0041, 1'b0);

    // clear flags, then negative flag written on the same edge as JLT
    EN = 1'b0; FLAG_WE = 1'b1; ALU_OUT = 16'h0005;
    step();
    check("pos_zr", {31'h0, ZR}, 32'h0);
    check("pos_ng", {31'h0, NG}, 32'h0);
    EN = 1'b1; ALU_OUT = 16'h8000; JMP = 3'b100; A = 16'h0100;
    step(); chk_pc("jlt_old_flags", 16'h0042, 1'b0);
    check("neg_ng", {31'h0, NG}, 32'h1);
    check("neg_zr", {31'h0, ZR}, 32'h0);
    step(); chk_pc("jlt_new_flags", 16'h0100, 1'b1);

    // JGT with NG=1 must not jump; 111 always jumps
    FLAG_WE = 1'b0; JMP = 3'b001; A = 16'h0200;
    step(); chk_pc("jgt_neg", 16'h0101, 1'b0);
    JMP = 3'b111; A = 16'hFFFF;
    step(); chk_pc("jmp_all", 16'hFFFF, 1'b1);

    // wrap-around then hold with EN low
    JMP = 3'b000;
    step(); chk_pc("wrap", 16'h0000, 1'b0);
    EN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_pc("hold", 16'h0000, 1'b0);
    end

    // reset beats a jump on the same edge
    EN = 1'b1; JMP = 3'b111; A = 16'h1234; RST = 1'b1;
    step(); chk_pc("rst_prio", 16'h0000, 1'b0);
    check("rst_prio_ng", {31'h0, NG}, 32'h0);
    RST = 1'b0; JMP = 3'b000;
    step(); chk_pc("post_rst", 16'h0001, 1'b0);

    // self-loop
    JMP = 3'b111; A = 16'h0010;
    step(); chk_pc("self_enter", 16'h0010, 1'b1);
    step(); chk_pc("self_1", 16'h0010, 1'b1);
`ifdef HALT_DETECT_EN
    check("halt_set", {31'h0, HALT}, 32'h1);
    FLAG_WE = 1'b1; ALU_OUT = 16'h8000; JMP = 3'b000;
    step(); chk_pc("halt_frozen", 16'h0010, 1'b0);
    check("halt_ng_frozen", {31'h0, NG}, 32'h0);
    check("halt_stays", {31'h0, HALT}, 32'h1);
    FLAG_WE = 1'b0; RST = 1'b1;
    step();
    check("halt_cleared", {31'h0, HALT}, 32'h0);
    chk_pc("halt_rst", 16'h0000, 1'b0);
`else
    check("no_halt", {31'h0, HALT}, 32'h0);
    step(); chk_pc("self_2", 16'h0010, 1'b1);
    check("no_halt2", {31'h0, HALT}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jump_pc.md
JUMP_PC -- requirements
Module: jump_pc

Interface
REQ-001 Parameter WIDTH, default 16: PC, target and ALU result width; SHALL be a multiple of 8.
REQ-002 Parameter RESET_VEC, default 16'h0000: PC value loaded on reset.
REQ-003 CLK  input  1  clock; all state SHALL update on its rising edge only.
REQ-004 RST  input  1  reset; synchronous and active-high, sampled on the rising edge of CLK.
REQ-005 EN  input  1  instruction-advance enable; PC SHALL change only when EN=1.
REQ-006 ALU_OUT  input  WIDTH  ALU result; sources the zero and negative flags.
REQ-007 FLAG_WE  input  1  flag-register write enable.
REQ-008 JMP  input  3  jump bits {JLT, JEQ, JGT} = JMP[2:0].
REQ-009 A  input  WIDTH  jump target address.
REQ-010 PC  output  WIDTH  registered program counter.
REQ-011 ZR  output  1  registered zero flag.
REQ-012 NG  output  1  registered negative flag.
REQ-013 TAKEN  output  1  registered; 1 for the cycle after a jump is loaded.
REQ-014 HALT  output  1  registered self-loop halt indicator (see REQ-030).

Function
REQ-015 Zero detect SHALL be the NOR of all ALU_OUT bits, built as an OR-reduction of WIDTH/8 byte slices (8-input OR per slice) followed by a final OR and inversion.
REQ-016 Negative detect SHALL be ALU_OUT[WIDTH-1].
REQ-017 On an edge with FLAG_WE=1: ZR <= zero detect, NG <= negative detect; with FLAG_WE=0, ZR and NG SHALL hold.
REQ-018 ZR and NG SHALL never both be 1 (ALU_OUT=0 yields NG=0).
REQ-019 Jump condition SHALL be cond = (JMP[2]&NG) | (JMP[1]&ZR) | (JMP[0]&~ZR&~NG), evaluated from the registered ZR/NG.
REQ-020 If FLAG_WE=1 and EN=1 on the same edge, cond SHALL use the pre-update flags.
REQ-021 JMP=3'b111 SHALL always jump; JMP=3'b000 SHALL never jump.
REQ-022 On an edge with EN=1 and cond=1: PC <= A, TAKEN <= 1.
REQ-023 On an edge with EN=1 and cond=0: PC <= PC+1 modulo 2^WIDTH, TAKEN <= 0.
REQ-024 On an edge with EN=0: PC holds, TAKEN <= 0, and flags still follow REQ-017.
REQ-025 Wrap-around: PC = all-ones with no jump SHALL yield PC = 0 on the next edge.
REQ-026 Latency: a jump decision SHALL be visible on PC and TAKEN exactly one cycle after the EN edge, with no combinational path from any input to any output.

Reset
REQ-027 On an edge with RST=1: PC <= RESET_VEC, ZR <= 0, NG <= 0, TAKEN <= 0, HALT <= 0.
REQ-028 RST SHALL take priority over EN, FLAG_WE and HALT; a jump presented on the same edge SHALL be discarded.
REQ-029 The first edge with RST=0 and EN=1 SHALL act on RESET_VEC (PC becomes RESET_VEC+1 or A).

Configuration
REQ-030 With HALT_DETECT_EN defined: an edge with EN=1, JMP=3'b111 and A==PC SHALL set HALT=1, and HALT SHALL then stay set until RST.
REQ-031 With HALT_DETECT_EN defined and HALT=1: PC, ZR and NG SHALL freeze, TAKEN SHALL be 0, and EN and FLAG_WE SHALL be ignored.
REQ-032 Without HALT_DETECT_EN: HALT SHALL be constant 0, and a self-jump SHALL reload PC with A each EN cycle with TAKEN=1.

Verification
REQ-033 RST=1 for 2 cycles, then EN=1 and JMP=0 for 3 cycles -> PC = 0000, 0001, 0002, 0003; TAKEN=0.
REQ-034 FLAG_WE=1 with ALU_OUT=0000, then EN=1, JMP=010, A=0040 -> ZR=1, NG=0, PC=0040, TAKEN=1 for one cycle.
REQ-035 FLAG_WE=1 with ALU_OUT=8000 and EN=1, JMP=100 on the same edge, with prior flags ZR=NG=0 -> no jump (old flags used); a repeat on the next edge -> jump taken.
REQ-036 PC=FFFF, EN=1, JMP=000 -> PC=0000; then EN=0 for 4 cycles -> PC holds 0000.
REQ-037 PC=0010, EN=1, JMP=111, A=0010 -> with HALT_DETECT_EN: HALT=1 and PC frozen until RST=1 clears it; without it: HALT=0, PC=0010, TAKEN=1 every cycle.
REQ-038 EN=1, JMP=111, A=1234 and RST=1 on the same edge -> PC=RESET_VEC, TAKEN=0.
